// File: rtl/mcs4_timing_pkg.sv
// Purpose: shared types, sizing helper and strobe ordering for the 4004 timing generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcs4_timing_pkg;

    // Eight instruction subcycles plus the stalled state. The numeric value of
    // A1..X3 doubles as the bit index of that subcycle's window strobe.
    typedef enum logic [3:0] {
        SC_A1   = 4'd0,
        SC_A2   = 4'd1,
        SC_A3   = 4'd2,
        SC_M1   = 4'd3,
        SC_M2   = 4'd4,
        SC_X1   = 4'd5,
        SC_X2   = 4'd6,
        SC_X3   = 4'd7,
        SC_IDLE = 4'd8
    } subcycle_e;

    // Strobe vector order: bit 0 = a12 ... bit 7 = x32.
    localparam int NUM_STB = 8;
    localparam int STB_A12 = 0;
    localparam int STB_A22 = 1;
    localparam int STB_A32 = 2;
    localparam int STB_M12 = 3;
    localparam int STB_M22 = 4;
    localparam int STB_X12 = 5;
    localparam int STB_X22 = 6;
    localparam int STB_X32 = 7;

    // Bits needed to hold the values 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One-hot window strobe for a subcycle; all zero while stalled.
    function automatic logic [NUM_STB-1:0] strobe_decode(input subcycle_e s);
        logic [3:0] idx;
        logic [NUM_STB-1:0] v;
        idx = s;
        v   = '0;
        if (s != SC_IDLE) begin
            v[idx[2:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/timing_generator_if.sv
// Purpose: bundles the timing generator's stall handshake, phase clocks and window strobes.
// Latency: n/a (wiring only).
// Backpressure: stall_req asks the generator to park at the next instruction boundary; stall_ack confirms.
interface timing_generator_if;
    logic stall_req;
    logic stall_ack;
    logic clk1;
    logic clk2;
    logic a12, a22, a32, m12, m22, x12, x22, x32;
    logic sync;
    logic poc;

    modport master (
        input  stall_req,
        output stall_ack, clk1, clk2,
        output a12, a22, a32, m12, m22, x12, x22, x32,
        output sync, poc
    );

    modport slave (
        output stall_req,
        input  stall_ack, clk1, clk2,
        input  a12, a22, a32, m12, m22, x12, x22, x32,
        input  sync, poc
    );
endinterface

// File: rtl/phase_clock_gen.sv
// Purpose: divides sysclk into the non-overlapping clk1/clk2 pair and flags each clk2 rising edge.
// Latency: clk1 rises on the first edge after reset release; clk2 rises T_CLK1+T_D12 edges later.
// Backpressure: none, free-running.
// Ports: sysclk, poc_n (sync active-low reset) in; clk1_o, clk2_o registered clocks, adv_o high
// during the sysclk cycle whose closing edge raises clk2.
module phase_clock_gen
    import mcs4_timing_pkg::*;
#(
    parameter int T_CLK1 = 19,
    parameter int T_D12  = 15,
    parameter int T_CLK2 = 19,
    parameter int T_D21  = 15
) (
    input  logic sysclk,
    input  logic poc_n,
    output logic clk1_o,
    output logic clk2_o,
    output logic adv_o
);
    localparam int P  = T_CLK1 + T_D12 + T_CLK2 + T_D21;
    localparam int PW = cnt_width(P);

    localparam logic [PW-1:0] P_LAST  = PW'(P - 1);
    localparam logic [PW-1:0] C1_END  = PW'(T_CLK1);
    localparam logic [PW-1:0] C2_RISE = PW'(T_CLK1 + T_D12);
    localparam logic [PW-1:0] C2_END  = PW'(T_CLK1 + T_D12 + T_CLK2);

    // p_q is the phase the next edge presents on clk1/clk2, so each clock
    // register is a plain decode of p_q and never glitches.
    logic [PW-1:0] p_q, p_d;
    logic          clk1_q, clk2_q;

    assign p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;

    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            p_q    <= '0;
            clk1_q <= 1'b0;
            clk2_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            clk1_q <= (p_q < C1_END);
            clk2_q <= (p_q >= C2_RISE) && (p_q < C2_END);
        end
    end

    assign clk1_o = clk1_q;
    assign clk2_o = clk2_q;
    assign adv_o  = (p_q == C2_RISE);

endmodule

// File: rtl/timing_generator.sv
// Purpose: 4004 master timing: subcycle sequencer, window strobes, SYNC, stretched POC, stall handshake.
// Latency: strobes/stall_ack/poc change on the same sysclk edge that raises clk2.
// Backpressure: stall_req seen at the X3 boundary parks the sequence in IDLE until it drops.
// Ports: sysclk, poc_n (sync active-low reset) plain; tg (master modport) carries stall_req in and
// stall_ack, clk1, clk2, a12..x32, sync, poc out.
module timing_generator
    import mcs4_timing_pkg::*;
#(
    parameter int T_CLK1     = 19,
    parameter int T_D12      = 15,
    parameter int T_CLK2     = 19,
    parameter int T_D21      = 15,
    parameter int POC_CYCLES = 2
) (
    input  logic               sysclk,
    input  logic               poc_n,
    timing_generator_if.master tg
);
    // The counter also sees the X3->A1 step out of reset, which starts rather
    // than completes a cycle, hence POC_CYCLES+1 boundaries before poc clears.
    localparam int            CW       = cnt_width(POC_CYCLES + 1);
    localparam logic [CW-1:0] POC_LAST = CW'(POC_CYCLES);

    logic                adv;
    subcycle_e           state_q, state_d;
    logic [NUM_STB-1:0]  stb_q;
    logic                ack_q;
    logic                poc_q, poc_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    phase_clock_gen #(
        .T_CLK1 (T_CLK1),
        .T_D12  (T_D12),
        .T_CLK2 (T_CLK2),
        .T_D21  (T_D21)
    ) u_phase (
        .sysclk (sysclk),
        .poc_n  (poc_n),
        .clk1_o (tg.clk1),
        .clk2_o (tg.clk2),
        .adv_o  (adv)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        poc_d   = poc_q;
        if (adv) begin
            case (state_q)
                SC_A1: state_d = SC_A2;
                SC_A2: state_d = SC_A3;
                SC_A3: state_d = SC_M1;
                SC_M1: state_d = SC_M2;
                SC_M2: state_d = SC_X1;
                SC_X1: state_d = SC_X2;
                SC_X2: state_d = SC_X3;
                SC_X3: begin
                    if (tg.stall_req) begin
                        state_d = SC_IDLE;
                    end else begin
                        state_d = SC_A1;
                        // Saturates once poc has cleared.
                        if (cnt_q == POC_LAST) begin
                            poc_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                SC_IDLE: state_d = tg.stall_req ? SC_IDLE : SC_A1;
                default: state_d = SC_X3;
            endcase
        end
    end

    // Outputs are registered from the next state so they switch with clk2.
    always_ff @(posedge sysclk) begin
        if (!poc_n) begin
            state_q <= SC_X3;
            stb_q   <= strobe_decode(SC_X3);
            ack_q   <= 1'b0;
            poc_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stb_q   <= strobe_decode(state_d);
            ack_q   <= (state_d == SC_IDLE);
            poc_q   <= poc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tg.a12       = stb_q[STB_A12];
    assign tg.a22       = stb_q[STB_A22];
    assign tg.a32       = stb_q[STB_A32];
    assign tg.m12       = stb_q[STB_M12];
    assign tg.m22       = stb_q[STB_M22];
    assign tg.x12       = stb_q[STB_X12];
    assign tg.x22       = stb_q[STB_X22];
    assign tg.x32       = stb_q[STB_X32];
    assign tg.sync      = stb_q[STB_X32];
    assign tg.stall_ack = ack_q;
    assign tg.poc       = poc_q;

endmodule

// File: tb/tb_timing_generator.sv
// Purpose: self-checking bench for timing_generator against a cycle-count reference model.
// Latency: n/a.
// Backpressure: drives stall_req directly, directed and randomized.
module tb_timing_generator;
    localparam int T1  = 19;
    localparam int D12 = 15;
    localparam int T2  = 19;
    localparam int D21 = 15;
    localparam int P   = T1 + D12 + T2 + D21;
    localparam int POC = 2;
    localparam int C2R = T1 + D12;
    localparam int C2F = T1 + D12 + T2;

    logic sysclk;
    logic poc_n;
    timing_generator_if tif ();

    timing_generator #(
        .T_CLK1     (T1),
        .T_D12      (D12),
        .T_CLK2     (T2),
        .T_D21      (D21),
        .POC_CYCLES (POC)
    ) dut (
        .sysclk (sysclk),
        .poc_n  (poc_n),
        .tg     (tif)
    );

    initial sysclk = 1'b0;
    always #10 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    // Reference model: edges since release, subcycle index (8 = idle),
    // completed instruction cycles, and expected clock levels.
    int   m_k;
    int   m_sc;
    int   m_done;
    bit   m_in_cycle;
    bit   m_poc;
    bit   e_clk1, e_clk2;

    function automatic logic [12:0] obs_vec();
        return {tif.clk1, tif.clk2, tif.x32, tif.x22, tif.x12, tif.m22, tif.m12,
                tif.a32, tif.a22, tif.a12, tif.sync, tif.poc, tif.stall_ack};
    endfunction

    function automatic logic [12:0] exp_vec();
        logic [7:0] one;
        logic [7:0] stb;
        one = 8'd1;
        stb = (m_sc < 8) ? (one << m_sc) : 8'd0;
        return {e_clk1, e_clk2, stb, stb[7], m_poc, (m_sc == 8)};
    endfunction

    // One sysclk edge; the model consumes the inputs present at that edge.
    task automatic tick();
        logic rn, sr;
        int   ph;
        @(posedge sysclk);
        rn = poc_n;
        sr = tif.stall_req;
        #1;
        if (!rn) begin
            m_k = 0; m_sc = 7; m_done = 0; m_in_cycle = 0; m_poc = 1;
            e_clk1 = 0; e_clk2 = 0;
        end else begin
            m_k++;
            ph     = (m_k - 1) % P;
            e_clk1 = (ph < T1);
            e_clk2 = (ph >= C2R) && (ph < C2F);
            if (ph == C2R) begin
                if (m_sc == 7 || m_sc == 8) begin
                    if (sr) begin
                        m_sc = 8;
                    end else begin
                        if (m_sc == 7 && m_in_cycle) begin
                            m_done++;
                            if (m_done >= POC) m_poc = 0;
                        end
                        m_sc = 0;
                        m_in_cycle = 1;
                    end
                end else begin
                    m_sc++;
                end
            end
        end
    endtask

    task automatic test_reset();
        poc_n = 1'b0;
        tif.stall_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got=%b want=%b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clocks();
        int c1_hi = 0;
        int c2_rise = -1;
        logic c2_prev = 1'b0;
        poc_n = 1'b1;
        for (int i = 0; i < 2 * P; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clocks k=%0d got=%b want=%b", m_k, obs_vec(), exp_vec());
            end
            checks++;
            if ((tif.clk1 & tif.clk2) !== 1'b0) begin
                errors++;
                $display("FAIL clk_overlap k=%0d clk1=%b clk2=%b", m_k, tif.clk1, tif.clk2);
            end
            if (tif.clk1) c1_hi++;
            if (tif.clk2 && !c2_prev && c2_rise < 0) c2_rise = m_k;
            c2_prev = tif.clk2;
        end
        checks++;
        if (c1_hi != 2 * T1) begin
            errors++;
            $display("FAIL clk1_high_count got=%0d want=%0d", c1_hi, 2 * T1);
        end
        checks++;
        if (c2_rise != C2R + 1) begin
            errors++;
            $display("FAIL clk2_first_rise got=%0d want=%0d", c2_rise, C2R + 1);
        end
    endtask

    // Continues the run from test_clocks until past the poc release.
    task automatic test_free_run_poc();
        logic [7:0] prev;
        logic [7:0] cur;
        int         run [8];
        int         poc_fall = -1;
        logic       poc_prev = 1'b1;
        prev = {tif.x32, tif.x22, tif.x12, tif.m22, tif.m12, tif.a32, tif.a22, tif.a12};
        for (int i = 0; i < 8; i++) run[i] = 0;
        while (m_k < C2R + 1 + 17 * 8 * P / 8 * 1 && m_k < 1300) begin
            tick();
            cur = {tif.x32, tif.x22, tif.x12, tif.m22, tif.m12, tif.a32, tif.a22, tif.a12};
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL free_run k=%0d got=%b want=%b", m_k, obs_vec(), exp_vec());
            end
            for (int s = 0; s < 8; s++) begin
                if (cur[s] && !prev[s]) begin
                    run[s] = 1;
                end else if (cur[s] && run[s] > 0) begin
                    run[s]++;
                end else if (!cur[s] && prev[s] && run[s] > 0) begin
                    checks++;
                    if (run[s] != P) begin
                        errors++;
                        $display("FAIL strobe_width idx=%0d got=%0d want=%0d", s, run[s], P);
                    end
                    run[s] = 0;
                end
            end
            if (tif.clk2 && m_sc == 3) begin
                checks++;
                if (tif.m12 !== 1'b1) begin
                    errors++;
                    $display("FAIL m12_in_clk2 k=%0d got=%b want=1", m_k, tif.m12);
                end
            end
            if (poc_prev && !tif.poc && poc_fall < 0) begin
                poc_fall = m_k;
                checks++;
                if (!(tif.a12 && !prev[0])) begin
                    errors++;
                    $display("FAIL poc_a12_align k=%0d got_a12=%b prev_a12=%b want rising", m_k, tif.a12, prev[0]);
                end
            end
            poc_prev = tif.poc;
            prev = cur;
        end
        checks++;
        if (poc_fall != C2R + 1 + 2 * 8 * P) begin
            errors++;
            $display("FAIL poc_fall_edge got=%0d want=%0d", poc_fall, C2R + 1 + 2 * 8 * P);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int acks = 0;
        bit ok = 1;
        while (m_sc != 6 && n < 1000) begin tick(); n++; end
        if (m_sc != 6) ok = 0;
        tif.stall_req = 1'b1;
        n = 0;
        while (m_sc != 8 && n < 1000) begin
            tick(); n++;
            if (tif.stall_ack) acks++;
        end
        if (m_sc != 8) ok = 0;
        for (int i = 0; i < P + 12; i++) begin
            tick();
            if (tif.stall_ack) acks++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall_idle k=%0d got=%b want=%b", m_k, obs_vec(), exp_vec());
            end
        end
        tif.stall_req = 1'b0;
        n = 0;
        while (tif.a12 !== 1'b1 && n < 200) begin
            tick(); n++;
            if (tif.stall_ack) acks++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall_exit k=%0d got=%b want=%b", m_k, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (!ok || tif.a12 !== 1'b1 || tif.stall_ack !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume reached=%0d a12=%b ack=%b want a12=1 ack=0", ok, tif.a12, tif.stall_ack);
        end
        checks++;
        if (acks != 2 * P) begin
            errors++;
            $display("FAIL stall_ack_cycles got=%0d want=%0d", acks, 2 * P);
        end
    endtask

    task automatic test_stall_pulse();
        int n = 0;
        int acks = 0;
        while (m_sc != 3 && n < 1000) begin tick(); n++; end
        checks++;
        if (m_sc != 3) begin
            errors++;
            $display("FAIL pulse_wait_m1 timeout got_sc=%0d want=3", m_sc);
        end
        tif.stall_req = 1'b1;
        tick();
        tif.stall_req = 1'b0;
        for (int i = 0; i < 8 * P + 10; i++) begin
            tick();
            if (tif.stall_ack) acks++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall_pulse k=%0d got=%b want=%b", m_k, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL stall_pulse_ack got=%0d want=0", acks);
        end
    endtask

    task automatic test_midreset();
        int n = 0;
        int a12_rise = -1;
        logic a12_prev;
        while (!(m_sc == 4 && tif.clk2 === 1'b1) && n < 1000) begin tick(); n++; end
        checks++;
        if (!(m_sc == 4 && tif.clk2 === 1'b1)) begin
            errors++;
            $display("FAIL midreset_wait timeout sc=%0d clk2=%b want sc=4 clk2=1", m_sc, tif.clk2);
        end
        poc_n = 1'b0;
        tick();
        checks++;
        if (tif.clk2 !== 1'b0 || tif.x32 !== 1'b1 || tif.m22 !== 1'b0 || tif.poc !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state clk2=%b x32=%b m22=%b poc=%b want 0 1 0 1",
                     tif.clk2, tif.x32, tif.m22, tif.poc);
        end
        tick();
        poc_n = 1'b1;
        a12_prev = tif.a12;
        for (int i = 0; i < 8 * P; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midreset_restart k=%0d got=%b want=%b", m_k, obs_vec(), exp_vec());
            end
            if (tif.a12 && !a12_prev && a12_rise < 0) a12_rise = m_k;
            a12_prev = tif.a12;
        end
        checks++;
        if (a12_rise != C2R + 1) begin
            errors++;
            $display("FAIL midreset_a12_rise got=%0d want=%0d", a12_rise, C2R + 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            if (m_poc == 0 && $urandom_range(149, 0) == 0) tif.stall_req = ~tif.stall_req;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random k=%0d got=%b want=%b", m_k, obs_vec(), exp_vec());
            end
        end
        tif.stall_req = 1'b0;
    endtask

    initial begin
        poc_n = 1'b0;
        tif.stall_req = 1'b0;
        m_k = 0; m_sc = 7; m_done = 0; m_in_cycle = 0; m_poc = 1;
        e_clk1 = 0; e_clk2 = 0;
        test_reset();
        test_clocks();
        test_free_run_poc();
        test_stall();
        test_stall_pulse();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
